// File: rtl/relm_vga_scan.sv
`default_nettype none
// ============================================================================
// Module   : relm_vga_scan
// Purpose  : Parametrised VGA scan-out engine fed from ReLM push ports.
//            Generates H/V timing, pops packed pixel words from a FIFO,
//            expands them through a palette and drives the DAC/sync pins
//            with a fixed 3-clock counter-to-pin latency.
// Ports    : clk        - system clock
//            rst_in     - synchronous active-high reset
//            vga_d      - pixel word push ([WD]=strobe, first pixel in MSBs)
//            vga_retry  - FIFO full, push ignored while high
//            pal_d      - palette push ([WD]=strobe, [BPP-1:0]=index,
//                         [BPP+3*WRGB-1:BPP]={r,g,b})
//            stat_d     - status control ([WD]&[11] clears underflow)
//            stat_q     - status word (line, vblank, underflow, FIFO level)
//            r_out/g_out/b_out - colour channels
//            hs_out/vs_out     - syncs, active low
//            de_out            - data enable, aligned with colour
// Revision : 1.0 - initial release
// ============================================================================
module relm_vga_scan #(
    parameter int WD       = 32,
    parameter int WAD      = 8,
    parameter int BPP      = 4,
    parameter int WRGB     = 4,
    parameter int CLKDIV   = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic [WD:0]     vga_d,
    output logic            vga_retry,
    input  logic [WD:0]     pal_d,
    input  logic [WD:0]     stat_d,
    output logic [WD:0]     stat_q,
    output logic [WRGB-1:0] r_out,
    output logic [WRGB-1:0] g_out,
    output logic [WRGB-1:0] b_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic            de_out
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_HTOT  = (H_ACTIVE + H_FP + H_SYNC + H_BP) * CLKDIV;
    localparam int c_VTOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW    = (c_HTOT > 1) ? $clog2(c_HTOT) : 1;
    localparam int c_VW    = (c_VTOT > 1) ? $clog2(c_VTOT) : 1;
    localparam int c_PPW   = WD / BPP;
    localparam int c_PW    = (c_PPW > 1) ? $clog2(c_PPW) : 1;
    localparam int c_DW    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int c_DEPTH = 2 ** WAD;
    localparam int c_CW    = 3 * WRGB;

    localparam logic [c_HW-1:0]  c_H_LAST    = c_HW'(c_HTOT - 1);
    localparam logic [c_HW-1:0]  c_H_ACT_END = c_HW'(H_ACTIVE * CLKDIV);
    localparam logic [c_HW-1:0]  c_HS_BEG    = c_HW'((H_ACTIVE + H_FP) * CLKDIV);
    localparam logic [c_HW-1:0]  c_HS_END    = c_HW'((H_ACTIVE + H_FP + H_SYNC) * CLKDIV);
    localparam logic [c_VW-1:0]  c_V_LAST    = c_VW'(c_VTOT - 1);
    localparam logic [c_VW-1:0]  c_V_ACT_END = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0]  c_VS_BEG    = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0]  c_VS_END    = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_DW-1:0]  c_DIV_LAST  = c_DW'(CLKDIV - 1);
    localparam logic [c_PW-1:0]  c_PIX_LAST  = c_PW'(c_PPW - 1);
    localparam logic [WAD:0]     c_FULL      = (WAD + 1)'(c_DEPTH);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // counter stage
    logic [c_HW-1:0] r_hcnt_q,  w_hcnt_d;
    logic [c_VW-1:0] r_vcnt_q,  w_vcnt_d;
    logic [c_DW-1:0] r_div_q,   w_div_d;
    logic [c_PW-1:0] r_pix_q,   w_pix_d;
    // FIFO bookkeeping
    logic [WAD-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [WAD-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [WAD:0]    r_level_q,  w_level_d;
    // stage 1: shifter and timing flags
    logic [WD-1:0]   r_shift_q,  w_shift_d;
    logic            r_blk_q,    w_blk_d;
    logic            r_s1_de_q,  w_s1_de_d;
    logic            r_s1_hs_q,  w_s1_hs_d;
    logic            r_s1_vs_q,  w_s1_vs_d;
    // stage 2: palette output
    logic [c_CW-1:0] r_s2_rgb_q, w_s2_rgb_d;
    logic            r_s2_de_q,  w_s2_de_d;
    logic            r_s2_hs_q,  w_s2_hs_d;
    logic            r_s2_vs_q,  w_s2_vs_d;
    // stage 3: pin registers
    logic [c_CW-1:0] r_rgb_q,    w_rgb_d;
    logic            r_de_q,     w_de_d;
    logic            r_hs_n_q,   w_hs_n_d;
    logic            r_vs_n_q,   w_vs_n_d;
    // status
    logic            r_uf_q,     w_uf_d;
    logic [WD:0]     r_stat_q,   w_stat_d;

    logic [WD-1:0]   r_fifo_mem [c_DEPTH];
    logic [c_CW-1:0] r_pal_mem  [2**BPP];

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic            w_h_wrap;
    logic            w_div_last;
    logic            w_active;
    logic            w_hsync;
    logic            w_vsync;
    logic            w_group_start;
    logic            w_shift_step;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_uf_set;
    logic            w_uf_clr;
    logic [WD-1:0]   w_fifo_head;
    logic [BPP-1:0]  w_pix_idx;
    logic [c_CW-1:0] w_pal_rd;
    logic            w_unused_ok;

    assign w_h_wrap      = (r_hcnt_q == c_H_LAST);
    assign w_div_last    = (r_div_q == c_DIV_LAST);
    assign w_active      = (r_hcnt_q < c_H_ACT_END) && (r_vcnt_q < c_V_ACT_END);
    assign w_hsync       = (r_hcnt_q >= c_HS_BEG) && (r_hcnt_q < c_HS_END);
    assign w_vsync       = (r_vcnt_q >= c_VS_BEG) && (r_vcnt_q < c_VS_END);
    // A new word is needed on the first clock of each pixel group; the
    // following pixels of the group are produced by shifting.
    assign w_group_start = w_active && (r_div_q == '0) && (r_pix_q == '0);
    assign w_shift_step  = w_active && (r_div_q == '0) && (r_pix_q != '0);

    assign w_empty     = (r_level_q == '0);
    assign w_full      = (r_level_q == c_FULL);
    assign vga_retry   = w_full;
    // Full is taken from the registered level, so a push that coincides with
    // a pop while full is still rejected.
    assign w_push      = vga_d[WD] && !w_full;
    assign w_pop       = w_group_start && !w_empty;
    assign w_uf_set    = w_group_start && w_empty;
    assign w_uf_clr    = stat_d[WD] && stat_d[11];
    assign w_fifo_head = r_fifo_mem[r_rd_ptr_q];

    assign w_pix_idx   = r_shift_q[WD-1 -: BPP];
    assign w_pal_rd    = r_pal_mem[w_pix_idx];

    assign w_unused_ok = &{1'b0, pal_d[WD-1:BPP+c_CW], stat_d[WD-1:12], stat_d[10:0]};

    always_comb begin
        // scan counters
        w_hcnt_d = w_h_wrap ? '0 : r_hcnt_q + 1'b1;
        w_vcnt_d = r_vcnt_q;
        if (w_h_wrap) begin
            w_vcnt_d = (r_vcnt_q == c_V_LAST) ? '0 : r_vcnt_q + 1'b1;
        end
        w_div_d = (w_h_wrap || w_div_last) ? '0 : r_div_q + 1'b1;
        // Pixel-in-group restarts every line so a partial word is abandoned.
        w_pix_d = r_pix_q;
        if (w_h_wrap) begin
            w_pix_d = '0;
        end else if (w_active && w_div_last) begin
            w_pix_d = (r_pix_q == c_PIX_LAST) ? '0 : r_pix_q + 1'b1;
        end

        // FIFO pointers and level
        w_wr_ptr_d = w_push ? r_wr_ptr_q + 1'b1 : r_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? r_rd_ptr_q + 1'b1 : r_rd_ptr_q;
        w_level_d  = r_level_q;
        if (w_push && !w_pop) begin
            w_level_d = r_level_q + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_d = r_level_q - 1'b1;
        end

        // stage 1
        w_shift_d = r_shift_q;
        w_blk_d   = r_blk_q;
        if (w_group_start) begin
            w_shift_d = w_empty ? '0 : w_fifo_head;
            w_blk_d   = w_empty;
        end else if (w_shift_step) begin
            w_shift_d = {r_shift_q[WD-BPP-1:0], {BPP{1'b0}}};
        end
        w_s1_de_d = w_active;
        w_s1_hs_d = w_hsync;
        w_s1_vs_d = w_vsync;

        // stage 2: palette lookup, black for blanking and underflowed groups
        w_s2_rgb_d = (r_s1_de_q && !r_blk_q) ? w_pal_rd : '0;
        w_s2_de_d  = r_s1_de_q;
        w_s2_hs_d  = r_s1_hs_q;
        w_s2_vs_d  = r_s1_vs_q;

        // stage 3: pins, syncs inverted to active low
        w_rgb_d  = r_s2_rgb_q;
        w_de_d   = r_s2_de_q;
        w_hs_n_d = !r_s2_hs_q;
        w_vs_n_d = !r_s2_vs_q;

        // a new underflow outranks a simultaneous clear
        w_uf_d = r_uf_q;
        if (w_uf_set) begin
            w_uf_d = 1'b1;
        end else if (w_uf_clr) begin
            w_uf_d = 1'b0;
        end

        w_stat_d             = '0;
        w_stat_d[9:0]        = 10'(r_vcnt_q);
        w_stat_d[10]         = (r_vcnt_q >= c_V_ACT_END);
        w_stat_d[11]         = r_uf_q;
        w_stat_d[12 +: WAD+1] = r_level_q;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_hcnt_q   <= '0;
            r_vcnt_q   <= '0;
            r_div_q    <= '0;
            r_pix_q    <= '0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
            r_shift_q  <= '0;
            r_blk_q    <= 1'b0;
            r_s1_de_q  <= 1'b0;
            r_s1_hs_q  <= 1'b0;
            r_s1_vs_q  <= 1'b0;
            r_s2_rgb_q <= '0;
            r_s2_de_q  <= 1'b0;
            r_s2_hs_q  <= 1'b0;
            r_s2_vs_q  <= 1'b0;
            r_rgb_q    <= '0;
            r_de_q     <= 1'b0;
            r_hs_n_q   <= 1'b1;
            r_vs_n_q   <= 1'b1;
            r_uf_q     <= 1'b0;
            r_stat_q   <= '0;
        end else begin
            r_hcnt_q   <= w_hcnt_d;
            r_vcnt_q   <= w_vcnt_d;
            r_div_q    <= w_div_d;
            r_pix_q    <= w_pix_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
            r_shift_q  <= w_shift_d;
            r_blk_q    <= w_blk_d;
            r_s1_de_q  <= w_s1_de_d;
            r_s1_hs_q  <= w_s1_hs_d;
            r_s1_vs_q  <= w_s1_vs_d;
            r_s2_rgb_q <= w_s2_rgb_d;
            r_s2_de_q  <= w_s2_de_d;
            r_s2_hs_q  <= w_s2_hs_d;
            r_s2_vs_q  <= w_s2_vs_d;
            r_rgb_q    <= w_rgb_d;
            r_de_q     <= w_de_d;
            r_hs_n_q   <= w_hs_n_d;
            r_vs_n_q   <= w_vs_n_d;
            r_uf_q     <= w_uf_d;
            r_stat_q   <= w_stat_d;
        end
    end

    // Storage arrays carry no reset; the FIFO is emptied through its pointers
    // and the palette deliberately survives reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr_q] <= vga_d[WD-1:0];
        end
    end

    // Combinational read above sees the old entry on the write clock.
    always_ff @(posedge clk) begin
        if (pal_d[WD]) begin
            r_pal_mem[pal_d[BPP-1:0]] <= pal_d[BPP+c_CW-1:BPP];
        end
    end

    assign r_out  = r_rgb_q[c_CW-1 -: WRGB];
    assign g_out  = r_rgb_q[2*WRGB-1 -: WRGB];
    assign b_out  = r_rgb_q[WRGB-1:0];
    assign de_out = r_de_q;
    assign hs_out = r_hs_n_q;
    assign vs_out = r_vs_n_q;
    assign stat_q = r_stat_q;

endmodule
`default_nettype wire

// File: tb/tb_relm_vga_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_relm_vga_scan
// Purpose  : Directed self-checking bench for relm_vga_scan on a small
//            14x7 timing (H 8/2/2/2, V 4/1/1/1, CLKDIV 1, BPP 4, WAD 3).
//            Cycle k counts falling edges since reset release; the counter
//            value during cycle k is k (mod frame), and the pins show the
//            counter value k-3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relm_vga_scan;

    localparam int WD   = 32;
    localparam int WAD  = 3;
    localparam int BPP  = 4;
    localparam int WRGB = 4;

    logic            clk = 1'b0;
    logic            rst_in = 1'b0;
    logic [WD:0]     vga_d = '0;
    logic            vga_retry;
    logic [WD:0]     pal_d = '0;
    logic [WD:0]     stat_d = '0;
    logic [WD:0]     stat_q;
    logic [WRGB-1:0] r_out, g_out, b_out;
    logic            hs_out, vs_out, de_out;

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    relm_vga_scan #(
        .WD(WD), .WAD(WAD), .BPP(BPP), .WRGB(WRGB), .CLKDIV(1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk(clk), .rst_in(rst_in),
        .vga_d(vga_d), .vga_retry(vga_retry),
        .pal_d(pal_d),
        .stat_d(stat_d), .stat_q(stat_q),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out)
    );

    task automatic tick;
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) tick();
    endtask

    // Reference timing for counter value n on the 14x7 raster.
    function automatic logic ref_de(input int n);
        int h = n % 14;
        int v = (n / 14) % 7;
        return (h < 8) && (v < 4);
    endfunction
    function automatic logic ref_hs(input int n);
        int h = n % 14;
        return !((h >= 10) && (h < 12));
    endfunction
    function automatic logic ref_vs(input int n);
        int v = (n / 14) % 7;
        return !(v == 5);
    endfunction

    task automatic test_reset;
        @(negedge clk);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({r_out, g_out, b_out} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h want=000", {r_out, g_out, b_out}); end
        checks++; if (hs_out !== 1'b1) begin errors++; $display("FAIL reset_hs got=%b want=1", hs_out); end
        checks++; if (vs_out !== 1'b1) begin errors++; $display("FAIL reset_vs got=%b want=1", vs_out); end
        checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL reset_de got=%b want=0", de_out); end
        checks++; if (vga_retry !== 1'b0) begin errors++; $display("FAIL reset_retry got=%b want=0", vga_retry); end
        checks++; if (stat_q !== 33'h0) begin errors++; $display("FAIL reset_stat got=%h want=0", stat_q); end
        rst_in = 1'b0;
        k = 0;
        tick(); tick();
        checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL first_de_early k=%0d got=%b want=0", k, de_out); end
        tick();
        checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL first_de k=%0d got=%b want=1", k, de_out); end
    endtask

    // One full frame with an empty FIFO: syncs/de follow the raster and the
    // visible area stays black.
    task automatic test_timing;
        while (k <= 100) begin
            checks++; if (hs_out !== ref_hs(k - 3)) begin errors++; $display("FAIL timing_hs k=%0d got=%b want=%b", k, hs_out, ref_hs(k - 3)); end
            checks++; if (vs_out !== ref_vs(k - 3)) begin errors++; $display("FAIL timing_vs k=%0d got=%b want=%b", k, vs_out, ref_vs(k - 3)); end
            checks++; if (de_out !== ref_de(k - 3)) begin errors++; $display("FAIL timing_de k=%0d got=%b want=%b", k, de_out, ref_de(k - 3)); end
            checks++; if ({r_out, g_out, b_out} !== 12'h000) begin errors++; $display("FAIL underflow_black k=%0d got=%h want=000", k, {r_out, g_out, b_out}); end
            tick();
        end
    endtask

    task automatic test_underflow_clear;
        checks++; if (stat_q[11] !== 1'b1) begin errors++; $display("FAIL uf_set got=%b want=1", stat_q[11]); end
        run_to(154);                       // frame 1, line 4 (vblank)
        stat_d = 33'h1_0000_0800;
        tick();
        stat_d = '0;
        tick();
        checks++; if (stat_q[11] !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b want=0", stat_q[11]); end
        run_to(196);                       // frame 2 line 0 pixel 0: empty pop
        stat_d = 33'h1_0000_0800;
        tick();
        stat_d = '0;
        tick();
        checks++; if (stat_q[11] !== 1'b1) begin errors++; $display("FAIL uf_set_wins got=%b want=1", stat_q[11]); end
    endtask

    task automatic test_pixels;
        run_to(252);                       // frame 2 vblank
        stat_d = 33'h1_0000_0800;
        tick();
        stat_d = '0;
        pal_d = {1'b1, 16'h0, 12'hF00, 4'h1};
        tick();
        pal_d = {1'b1, 16'h0, 12'h0F0, 4'h2};
        tick();
        pal_d = '0;
        for (int i = 0; i < 4; i++) begin
            vga_d = {1'b1, 32'h12121212};
            tick();
        end
        vga_d = '0;
        tick();
        checks++; if (stat_q[15:12] !== 4'd4) begin errors++; $display("FAIL push_level got=%0d want=4", stat_q[15:12]); end
        checks++; if (stat_q[11] !== 1'b0) begin errors++; $display("FAIL pre_frame_uf got=%b want=0", stat_q[11]); end
        run_to(297);                       // pins show frame 3 line 0 pixel 0
        for (int p = 0; p < 8; p++) begin
            logic [11:0] want;
            want = (p % 2 == 0) ? 12'hF00 : 12'h0F0;
            checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL line0_de p=%0d got=%b want=1", p, de_out); end
            checks++; if ({r_out, g_out, b_out} !== want) begin errors++; $display("FAIL line0_rgb p=%0d got=%h want=%h", p, {r_out, g_out, b_out}, want); end
            tick();
        end
        checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL line0_end_de got=%b want=0", de_out); end
        checks++; if ({r_out, g_out, b_out} !== 12'h000) begin errors++; $display("FAIL line0_end_rgb got=%h want=000", {r_out, g_out, b_out}); end
    endtask

    // Counter 308 (line 1 pixel 0, idx1) is looked up during cycle 309.
    task automatic test_pal_same_clock;
        run_to(309);
        pal_d = {1'b1, 16'h0, 12'h00F, 4'h1};
        tick();
        pal_d = '0;
        tick();
        checks++; if ({r_out, g_out, b_out} !== 12'hF00) begin errors++; $display("FAIL pal_old got=%h want=F00", {r_out, g_out, b_out}); end
        tick();
        checks++; if ({r_out, g_out, b_out} !== 12'h0F0) begin errors++; $display("FAIL pal_idx2 got=%h want=0F0", {r_out, g_out, b_out}); end
        tick();
        checks++; if ({r_out, g_out, b_out} !== 12'h00F) begin errors++; $display("FAIL pal_new got=%h want=00F", {r_out, g_out, b_out}); end
        run_to(351);                       // stat reflects frame 3 line 4
        checks++; if (stat_q[11] !== 1'b0) begin errors++; $display("FAIL frame_uf got=%b want=0", stat_q[11]); end
        checks++; if (stat_q[15:12] !== 4'd0) begin errors++; $display("FAIL frame_level got=%0d want=0", stat_q[15:12]); end
        checks++; if (stat_q[10] !== 1'b1) begin errors++; $display("FAIL vblank got=%b want=1", stat_q[10]); end
        checks++; if (stat_q[9:0] !== 10'd4) begin errors++; $display("FAIL line got=%0d want=4", stat_q[9:0]); end
    endtask

    task automatic test_fifo_full;
        for (int i = 0; i < 11; i++) begin
            vga_d = {1'b1, (i == 0) ? 32'h11111111 : 32'h22222222};
            if (k == 358) begin
                checks++; if (vga_retry !== 1'b0) begin errors++; $display("FAIL retry_early got=%b want=0", vga_retry); end
            end
            if (k == 359) begin
                checks++; if (vga_retry !== 1'b1) begin errors++; $display("FAIL retry_full got=%b want=1", vga_retry); end
            end
            tick();
        end
        vga_d = '0;
        tick();
        checks++; if (stat_q[15:12] !== 4'd8) begin errors++; $display("FAIL full_level got=%0d want=8", stat_q[15:12]); end
        checks++; if (vga_retry !== 1'b1) begin errors++; $display("FAIL full_retry got=%b want=1", vga_retry); end
        run_to(392);                       // frame 4 line 0 pop, push while full
        vga_d = {1'b1, 32'h22222222};
        tick();
        vga_d = '0;
        checks++; if (vga_retry !== 1'b0) begin errors++; $display("FAIL retry_after_pop got=%b want=0", vga_retry); end
        tick();
        checks++; if (stat_q[15:12] !== 4'd7) begin errors++; $display("FAIL pop_level got=%0d want=7", stat_q[15:12]); end
        tick();
        checks++; if ({r_out, g_out, b_out} !== 12'h00F) begin errors++; $display("FAIL first_word_rgb got=%h want=00F", {r_out, g_out, b_out}); end
    endtask

    task automatic test_midframe_reset;
        run_to(424);                       // pins mid line 2, level 5
        checks++; if (stat_q[15:12] !== 4'd5) begin errors++; $display("FAIL pre_reset_level got=%0d want=5", stat_q[15:12]); end
        checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL pre_reset_de got=%b want=1", de_out); end
        rst_in = 1'b1;
        tick();
        checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL mid_reset_de got=%b want=0", de_out); end
        checks++; if (hs_out !== 1'b1 || vs_out !== 1'b1) begin errors++; $display("FAIL mid_reset_sync got=%b%b want=11", hs_out, vs_out); end
        checks++; if (stat_q[15:12] !== 4'd0) begin errors++; $display("FAIL mid_reset_level got=%0d want=0", stat_q[15:12]); end
        checks++; if ({r_out, g_out, b_out} !== 12'h000) begin errors++; $display("FAIL mid_reset_rgb got=%h want=000", {r_out, g_out, b_out}); end
        rst_in = 1'b0;
        k = 0;
        tick(); tick();
        checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL restart_de_early got=%b want=0", de_out); end
        tick();
        checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL restart_de got=%b want=1", de_out); end
        checks++; if ({r_out, g_out, b_out} !== 12'h000) begin errors++; $display("FAIL restart_flushed_rgb got=%h want=000", {r_out, g_out, b_out}); end
        run_to(13);
        checks++; if (hs_out !== 1'b0) begin errors++; $display("FAIL restart_hs got=%b want=0", hs_out); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_underflow_clear();
        test_pixels();
        test_pal_same_clock();
        test_fifo_full();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
